mask_index_walker: RTL and testbench
====================================

Name: mask_index_walker

Overview:
- Sequencer that accepts a bit mask and emits the index of every set bit, highest index first, one index per accepted output beat.
- Each beat floor-log2 priority-encodes the remaining mask, then clears the emitted bit.
- Sits between a mask producer (e.g. an active-channel or active-neuron mask) and a per-index consumer.
- Uses valid/ready handshakes on both sides.

Parameters:
- BIT_WIDTH, 16, mask width; legal range BIT_WIDTH >= 2.
- IDX_WIDTH, $clog2(BIT_WIDTH), index width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents in_mask.
- in_ready  output  1  walker can accept a mask.
- in_mask  input  BIT_WIDTH  mask to walk.
- flush  input  1  synchronous abort of the current walk.
- out_valid  output  1  out_index is valid.
- out_ready  input  1  consumer accepts out_index.
- out_index  output  IDX_WIDTH  index of highest set bit of the remaining mask.
- out_last  output  1  current beat is the final set bit of this mask.
- out_seq  output  IDX_WIDTH  ordinal of the current beat within the walk (0 = first).
- done  output  1  one-cycle pulse: walk complete.
- busy  output  1  high while in WALK.

Behaviour:
- Reset values: state=IDLE, mask_reg=0, seq_reg=0, done=0. in_ready=1, out_valid=0, out_index=0, out_last=0, out_seq=0, busy=0.
- States: IDLE, WALK.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready with in_mask != 0: mask_reg<=in_mask, seq_reg<=0, go to WALK.
  - On in_valid && in_ready with in_mask == 0: stay in IDLE; done=1 in the next cycle; no output beats.
- WALK:
  - in_ready=0, busy=1.
  - out_valid = !flush (combinational).
  - out_index = floor(log2(mask_reg)) = position of the highest set bit. Bit 0 alone yields index 0.
  - out_last=1 iff mask_reg has exactly one bit set.
  - out_seq = seq_reg.
  - out_index, out_last and out_seq are combinational from registered state and stay stable while out_valid && !out_ready.
- Output handshake (out_valid && out_ready):
  - Clear bit out_index in mask_reg; seq_reg<=seq_reg+1.
  - If out_last: go to IDLE; done=1 in the next cycle.
- Flush:
  - flush=1 in WALK: go to IDLE, mask_reg<=0, seq_reg<=0, no done pulse, no transfer that cycle (out_valid forced low).
  - flush in IDLE: ignored; a simultaneous in_valid is accepted normally.
- Latency:
  - Mask accepted at edge N; first out_valid in cycle N+1.
  - With out_ready held high, one beat per cycle; popcount(mask) beats total.
  - done is high in the cycle after the final beat, which is also the first IDLE cycle; a new mask may be accepted in that same cycle.
  - Minimum spacing between mask acceptances is popcount+1 cycles.
- done: registered, exactly one cycle wide, never high while busy=1.
- seq_reg width is IDX_WIDTH; the maximum beat count BIT_WIDTH gives a maximum ordinal of BIT_WIDTH-1, so there is no overflow.
- Backpressure: out_ready low for any number of cycles holds all outputs and state unchanged.
- rst has priority over flush and over both handshakes, in any state; it returns to reset values immediately at the next edge.

Test Plan:
- Reset, then in_mask=16'h8421 with out_ready=1 -> out_index 15,10,5,0 on consecutive cycles; out_seq 0..3; out_last only on index 0; done pulse in the following cycle; busy high for exactly 4 cycles.
- in_mask=16'h0000 -> no out_valid; done high exactly one cycle after acceptance; in_ready remains 1.
- in_mask=16'h0001 -> single beat with out_index=0, out_last=1, out_seq=0, then done.
- in_mask=16'hFFFF with out_ready toggling 1,0,1,0... -> indices 15..0 in order, each held stable while stalled; 16 beats total; no duplicates or skips.
- in_mask=16'h00F0, flush=1 after the first beat (index 7) -> out_valid low in the flush cycle; back in IDLE with no done; next mask 16'h0003 yields 1,0.
- Assert rst mid-walk of 16'h0F00 -> next cycle shows all reset values; a following mask 16'h0002 walks normally (index 1, then done).

Source files
------------

// File: rtl/mask_index_walker.sv
// -----------------------------------------------------------------------------
// mask_index_walker
//
// Accepts a bit mask and emits the index of every set bit, highest index
// first, one index per accepted output beat. Each beat priority-encodes the
// highest set bit of the remaining mask and clears it once the beat is taken.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous, active-high reset (priority over everything)
//   in_valid   producer presents in_mask
//   in_ready   walker can accept a mask (high in IDLE)
//   in_mask    mask to walk
//   flush      synchronous abort of the current walk (ignored in IDLE)
//   out_valid  out_index is valid (WALK and no flush)
//   out_ready  consumer accepts out_index
//   out_index  index of the highest set bit of the remaining mask
//   out_last   current beat is the final set bit of this mask
//   out_seq    ordinal of the current beat within the walk (0 = first)
//   done       one-cycle pulse, walk complete (also for an all-zero mask)
//   busy       high while walking
// -----------------------------------------------------------------------------
module mask_index_walker #(
  parameter  int BIT_WIDTH = 16,
  localparam int IDX_WIDTH = $clog2(BIT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_mask,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_WIDTH-1:0] out_index,
  output logic                 out_last,
  output logic [IDX_WIDTH-1:0] out_seq,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WALK = 1'b1
  } state_t;

  state_t               r_state;
  logic [BIT_WIDTH-1:0] r_mask;
  logic [IDX_WIDTH-1:0] r_seq;
  logic                 r_done;

  state_t               w_state_next;
  logic [BIT_WIDTH-1:0] w_mask_next;
  logic [IDX_WIDTH-1:0] w_seq_next;
  logic                 w_done_next;

  logic                 w_in_walk;
  logic [IDX_WIDTH-1:0] w_top_idx;
  logic                 w_one_hot;
  logic [BIT_WIDTH-1:0] w_top_bit;

  // Priority encoder: scanning upward lets the highest set bit win.
  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_top_idx = '0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      if (r_mask[i]) w_top_idx = IDX_WIDTH'(i);
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_one_hot = (r_mask != '0) &&
                     ((r_mask & (r_mask - BIT_WIDTH'(1))) == '0);
  assign w_top_bit = BIT_WIDTH'(1) << w_top_idx;

  assign w_in_walk = (r_state == S_WALK);

  // Outputs are combinational from registered state, so they hold under stall.
  assign in_ready  = !w_in_walk;
  assign busy      = w_in_walk;
  assign out_valid = w_in_walk && !flush;
  assign out_index = w_in_walk ? w_top_idx : '0;
  assign out_last  = w_in_walk && w_one_hot;
  assign out_seq   = w_in_walk ? r_seq : '0;
  assign done      = r_done;

  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    w_seq_next   = r_seq;
    w_done_next  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (in_mask != '0) begin
            w_state_next = S_WALK;
            w_mask_next  = in_mask;
            w_seq_next   = '0;
          end else begin
            // Nothing to walk: report completion without any output beats.
            w_done_next = 1'b1;
          end
        end
      end

      S_WALK: begin
        if (flush) begin
          // Abort drops the walk silently; out_valid is already forced low.
          w_state_next = S_IDLE;
          w_mask_next  = '0;
          w_seq_next   = '0;
        end else if (out_ready) begin
          w_mask_next = r_mask & ~w_top_bit;
          w_seq_next  = r_seq + 1'b1;
          if (w_one_hot) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_seq   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
      r_seq   <= w_seq_next;
      r_done  <= w_done_next;
    end
  end

endmodule

// File: tb/tb_mask_index_walker.sv
// -----------------------------------------------------------------------------
// tb_mask_index_walker
//
// Directed plus randomized stimulus for mask_index_walker. The expected beat
// list for each mask is built by scanning the mask from the top bit down into
// a queue; every cycle's outputs are compared against that list.
// -----------------------------------------------------------------------------
module tb_mask_index_walker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mask;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic        out_last;
  logic [3:0]  out_seq;
  logic        done;
  logic        busy;

  int n_cmp;
  int n_mis;
  int exp_q[$];
  logic pd;

  mask_index_walker #(.BIT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_seq   (out_seq),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle: flush and out_ready are random since both must be ignored.
  task automatic idle_check(input logic exp_done);
    in_valid  = 1'b0;
    in_mask   = 16'($urandom);
    flush     = 1'($urandom % 2);
    out_ready = 1'($urandom % 2);
    @(negedge clk);
    check("idle_in_ready",  in_ready,  1);
    check("idle_out_valid", out_valid, 0);
    check("idle_busy",      busy,      0);
    check("idle_done",      done,      exp_done);
    check("idle_out_index", out_index, 0);
    check("idle_out_last",  out_last,  0);
    check("idle_out_seq",   out_seq,   0);
    tick();
  endtask

  // Present mask m in IDLE, then follow the walk beat by beat.
  // mode: 0 = out_ready high, 1 = toggling 1,0,1,..., 2 = random.
  // abort_beat: beat at which flush (or rst if abort_is_rst) is applied.
  // pend_done: whether done is expected in the cycle after return.
  task automatic do_mask(input logic [15:0] m, input int mode,
                         input logic exp_done_start, input int abort_beat,
                         input bit abort_is_rst, output logic pend_done);
    int n;
    int beat;
    int cyc;
    exp_q.delete();
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) exp_q.push_back(i);
    end
    n = exp_q.size();

    in_valid  = 1'b1;
    in_mask   = m;
    flush     = (mode == 2) ? 1'($urandom % 2) : 1'b0;
    out_ready = 1'($urandom % 2);
    @(negedge clk);
    check("acc_in_ready",  in_ready,  1);
    check("acc_out_valid", out_valid, 0);
    check("acc_done",      done,      exp_done_start);
    tick();

    pend_done = 1'b1;
    beat = 0;
    cyc  = 0;
    while (beat < n && cyc < 400) begin
      if (beat == abort_beat) begin
        in_valid  = 1'b1;
        in_mask   = 16'($urandom);
        out_ready = 1'b1;
        if (abort_is_rst) rst = 1'b1;
        else              flush = 1'b1;
        @(negedge clk);
        if (!abort_is_rst) begin
          check("flush_out_valid", out_valid, 0);
          check("flush_busy",      busy,      1);
          check("flush_done",      done,      0);
        end
        tick();
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        pend_done = 1'b0;
        return;
      end
      // Junk offers during the walk must be refused.
      in_valid = 1'($urandom % 2);
      in_mask  = 16'($urandom);
      flush    = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom % 2);
      endcase
      @(negedge clk);
      check("walk_out_valid", out_valid, 1);
      check("walk_busy",      busy,      1);
      check("walk_in_ready",  in_ready,  0);
      check("walk_done",      done,      0);
      check("walk_out_index", out_index, exp_q[beat]);
      check("walk_out_last",  out_last,  (beat == n - 1) ? 1 : 0);
      check("walk_out_seq",   out_seq,   beat);
      if (out_ready) beat++;
      cyc++;
      tick();
    end
    in_valid = 1'b0;
    check("beat_count", beat, n);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_check(1'b0);

    // Sparse mask, full-speed consumer; a zero mask is accepted in the done
    // cycle, then done follows one cycle later with no beats.
    do_mask(16'h8421, 0, 1'b0, -1, 1'b0, pd);
    do_mask(16'h0000, 0, pd,   -1, 1'b0, pd);
    idle_check(pd);
    idle_check(1'b0);

    // Single bit 0.
    do_mask(16'h0001, 0, 1'b0, -1, 1'b0, pd);
    idle_check(pd);
    idle_check(1'b0);

    // Full mask with out_ready toggling.
    do_mask(16'hFFFF, 1, 1'b0, -1, 1'b0, pd);
    idle_check(pd);
    idle_check(1'b0);

    // Flush after the first beat; next mask follows with no done pulse.
    do_mask(16'h00F0, 0, 1'b0, 1, 1'b0, pd);
    do_mask(16'h0003, 0, pd,  -1, 1'b0, pd);
    idle_check(pd);
    idle_check(1'b0);

    // Reset mid-walk, then a normal walk.
    do_mask(16'h0F00, 0, 1'b0, 2, 1'b1, pd);
    idle_check(1'b0);
    do_mask(16'h0002, 0, 1'b0, -1, 1'b0, pd);
    idle_check(pd);
    idle_check(1'b0);

    // Random masks, random backpressure, occasional flush, some chained.
    pd = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] m;
      int sel;
      int ab;
      sel = int'($urandom % 4);
      if (sel == 0)      m = 16'h0000;
      else if (sel == 1) m = 16'($urandom & $urandom & $urandom);
      else               m = 16'($urandom);
      ab = ($urandom % 5 == 0) ? int'($urandom % 4) : -1;
      if ($urandom % 2 == 0) begin
        idle_check(pd);
        pd = 1'b0;
      end
      do_mask(m, 2, pd, ab, 1'b0, pd);
    end
    idle_check(pd);
    idle_check(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
